// File: rtl/dualport_wb_pkg.sv
// Shared types and default sizes for the dual-port Wishbone burst master.
// Contents:
//   DefAddrW / DefDataW / DefSelW  default word-address, data and byte-select widths
//   state_e                        burst FSM states
//   wb_req_t                       one Wishbone request beat (we, addr, sel, data) at default widths
package dualport_wb_pkg;

  localparam int unsigned DefAddrW = 11;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefSelW  = DefDataW / 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic                we;
    logic [DefAddrW-1:0] addr;
    logic [DefSelW-1:0]  sel;
    logic [DefDataW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/dualport_wb_master_if.sv
// Pipelined Wishbone request/response bundle toward one port of a dual-port RAM.
// Signals (named from the master's point of view):
//   wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o   request, driven by the master
//   wb_stall_i, wb_ack_i, wb_data_i                     response, driven by the slave
// Modports: master, slave.
interface dualport_wb_master_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_stall_i;
  logic              wb_ack_i;
  logic [DATA_W-1:0] wb_data_i;

  modport master (
    output wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
    input  wb_stall_i, wb_ack_i, wb_data_i
  );

  modport slave (
    input  wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
    output wb_stall_i, wb_ack_i, wb_data_i
  );

endinterface

// File: rtl/dualport_wb_req_reg.sv
// Stall-holding Wishbone request register.
// Holds stb plus one request beat; the beat stays frozen while the slave stalls.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   flush        drop stb immediately (abandoned burst)
//   load         capture load_req and raise stb; only legal when free=1
//   load_req     beat to capture
//   stall        slave stall input
//   stb, req     registered request outputs
//   accept       stb & ~stall: beat handed over this cycle
//   free         register empty or emptying this cycle, so a new beat may load
module dualport_wb_req_reg
  import dualport_wb_pkg::*;
#(
  parameter type req_t = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic load,
  input  req_t load_req,
  input  logic stall,
  output logic stb,
  output req_t req,
  output logic accept,
  output logic free
);

  logic stb_q;
  req_t req_q;

  always_comb begin
    accept = stb_q & ~stall;
    free   = ~stb_q | ~stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
      req_q <= '0;
    end else if (flush) begin
      stb_q <= 1'b0;
    end else if (load) begin
      stb_q <= 1'b1;
      req_q <= load_req;
    end else if (accept) begin
      // Fields keep their last value so we_o stays constant for the burst.
      stb_q <= 1'b0;
    end
  end

  assign stb = stb_q;
  assign req = req_q;

endmodule

// File: rtl/dualport_wb_master.sv
// Burst command to pipelined Wishbone master for one port of a dual-port RAM.
// A command (we, start addr, len 1..16 with 0 meaning 16, sel) issues one beat per cycle at
// consecutive word addresses (wrapping modulo 2^ADDR_W), tracks outstanding acks, streams read
// data out, and pulses done_o once every beat has been acked.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o           command handshake (ready only when idle)
//   cmd_we_i, cmd_addr_i, cmd_len_i, cmd_sel_i   command fields
//   wdata_valid_i/wdata_ready_o, wdata_i         write-beat stream
//   rdata_valid_o, rdata_o            one pulse per read ack
//   done_o                            one-cycle burst-complete pulse
//   err_o                             sticky ack-timeout flag
//   p0                                Wishbone master port
// Build option: DUALPORT_WB_MASTER_TIMEOUT_EN enables the ack watchdog (TIMEOUT_CYC cycles);
// otherwise err_o is tied low.
module dualport_wb_master
  import dualport_wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned SEL_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [4:0]        cmd_len_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  dualport_wb_master_if.master p0
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } req_t;

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;     // address of the next beat to load
  logic [SEL_W-1:0]  sel_q;
  logic [4:0]        left_q;     // beats not yet loaded
  logic [4:0]        out_q;      // accepted but not yet acked
  logic [4:0]        out_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              done_q;

  logic req_stb, req_accept, req_free, load, ack_v, timeout;
  req_t req_d, req_q;

  always_comb begin
    ack_v = p0.wb_ack_i & (out_q != 5'd0);
    load  = (state_q == StIssue) & req_free & (left_q != 5'd0) & (~we_q | wdata_valid_i) &
            ~timeout;
    req_d = '{we: we_q, addr: addr_q, sel: sel_q, data: (we_q ? wdata_i : '0)};
    out_d = out_q + 5'(req_accept) - 5'(ack_v);
  end

  dualport_wb_req_reg #(
    .req_t (req_t)
  ) u_req_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (timeout),
    .load     (load),
    .load_req (req_d),
    .stall    (p0.wb_stall_i),
    .stb      (req_stb),
    .req      (req_q),
    .accept   (req_accept),
    .free     (req_free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      addr_q        <= '0;
      sel_q         <= '0;
      left_q        <= 5'd0;
      out_q         <= 5'd0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      rdata_valid_q <= ack_v & ~we_q;
      if (ack_v && !we_q) begin
        rdata_q <= p0.wb_data_i;
      end
      out_q  <= out_d;
      done_q <= 1'b0;
      if (load) begin
        addr_q <= addr_q + ADDR_W'(1);
        left_q <= left_q - 5'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            addr_q  <= cmd_addr_i;
            sel_q   <= cmd_sel_i;
            left_q  <= (cmd_len_i == 5'd0) ? 5'd16 : cmd_len_i;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (timeout) begin
            out_q   <= 5'd0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (left_q == 5'd0 && (req_accept || !req_stb)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (timeout) begin
            out_q   <= 5'd0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (out_d == 5'd0) begin
            // Uses next count so an ack this cycle finishes without an extra wait.
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DUALPORT_WB_MASTER_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);

  logic [WdogW-1:0] wdog_q;
  logic             err_q;
  logic             wdog_run;

  always_comb begin
    wdog_run = ((state_q == StIssue) || (state_q == StDrain)) & (out_q != 5'd0) & ~ack_v;
    timeout  = wdog_run & (wdog_q == WdogW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (timeout) begin
        wdog_q <= '0;
        err_q  <= 1'b1;
      end else if (wdog_run) begin
        wdog_q <= wdog_q + WdogW'(1);
      end else begin
        wdog_q <= '0;
      end
      if (state_q == StIdle && cmd_valid_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign cmd_ready_o   = (state_q == StIdle);
  assign wdata_ready_o = load & we_q;
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_o       = rdata_q;
  assign done_o        = done_q;

  assign p0.wb_stb_o  = req_stb;
  assign p0.wb_we_o   = req_q.we;
  assign p0.wb_addr_o = req_q.addr;
  assign p0.wb_sel_o  = req_q.sel;
  assign p0.wb_data_o = req_q.data;

endmodule

// File: tb/tb_dualport_wb_master.sv
// Directed bench for dualport_wb_master: reset values, write burst, stalled write burst,
// read burst, address wrap, mid-burst reset with a late ack, and (with
// DUALPORT_WB_MASTER_TIMEOUT_EN) the ack watchdog.
module tb_dualport_wb_master;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [4:0]    cmd_len;
  logic [SW-1:0] cmd_sel;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata, rdata;
  logic          rdata_valid, done, err;

  always #5 clk = ~clk;

  dualport_wb_master_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();

  dualport_wb_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .cmd_sel_i     (cmd_sel),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready),
    .wdata_i       (wdata),
    .rdata_valid_o (rdata_valid),
    .rdata_o       (rdata),
    .done_o        (done),
    .err_o         (err),
    .p0            (p0)
  );

  // Responder and monitor.
  logic ack_en, stall_en, late_ack, mon_clr;
  int   cyc, acc_n, ack_n, rd_n, done_n, stall_seen, done_cyc, wd_idx;
  logic [AW-1:0] acc_addr [32];
  logic [DW-1:0] acc_data [32];
  logic          acc_we   [32];
  int            acc_cyc  [32];
  logic [DW-1:0] rd_data  [32];
  logic [AW-1:0] hold_addr [2];
  logic [DW-1:0] hold_data [2];
  logic [DW-1:0] wd_base;

  int checks = 0;
  int failures = 0;

  assign wdata = wd_base + DW'(wd_idx);
  // Stall the third beat (index 2) for two cycles when enabled.
  assign p0.wb_stall_i = stall_en && p0.wb_stb_o && (acc_n == 2) && (stall_seen < 2);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p0.wb_ack_i  <= late_ack || (ack_en && p0.wb_stb_o && !p0.wb_stall_i);
    // Read data = (addr - 15) * 17, so 0x010 -> 0x11, 0x011 -> 0x22, 0x012 -> 0x33.
    p0.wb_data_i <= ({21'b0, p0.wb_addr_o} - 32'd15) * 32'd17;
    if (mon_clr) begin
      acc_n <= 0; ack_n <= 0; rd_n <= 0; done_n <= 0; stall_seen <= 0; wd_idx <= 0;
    end else begin
      if (p0.wb_stb_o && !p0.wb_stall_i && acc_n < 32) begin
        acc_addr[acc_n] <= p0.wb_addr_o;
        acc_data[acc_n] <= p0.wb_data_o;
        acc_we[acc_n]   <= p0.wb_we_o;
        acc_cyc[acc_n]  <= cyc;
        acc_n <= acc_n + 1;
      end
      if (p0.wb_stb_o && p0.wb_stall_i && stall_seen < 2) begin
        hold_addr[stall_seen] <= p0.wb_addr_o;
        hold_data[stall_seen] <= p0.wb_data_o;
        stall_seen <= stall_seen + 1;
      end
      if (p0.wb_ack_i) ack_n <= ack_n + 1;
      if (rdata_valid && rd_n < 32) begin
        rd_data[rd_n] <= rdata;
        rd_n <= rd_n + 1;
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      if (wdata_valid && wdata_ready) wd_idx <= wd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [4:0] len);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_n == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_n != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stb"}, 32'(p0.wb_stb_o), 32'd0);
    check({tag, "_we"}, 32'(p0.wb_we_o), 32'd0);
    check({tag, "_addr"}, 32'(p0.wb_addr_o), 32'd0);
    check({tag, "_sel"}, 32'(p0.wb_sel_o), 32'd0);
    check({tag, "_data"}, p0.wb_data_o, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_wready"}, 32'(wdata_ready), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
    wdata_valid = 1'b0; wd_base = '0;
    ack_en = 1'b1; stall_en = 1'b0; late_ack = 1'b0; mon_clr = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Write burst, no stall.
    clear_mon();
    wd_base = 32'hAA;
    wdata_valid = 1'b1;
    send_cmd(1'b1, 11'h400, 5'd4);
    wait_done("wr_done_seen", 40);
    check("wr_accepts", 32'(acc_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("wr_addr", 32'(acc_addr[i]), 32'h400 + 32'(i));
      check("wr_data", acc_data[i], 32'hAA + 32'(i));
      check("wr_we", 32'(acc_we[i]), 32'd1);
    end
    check("wr_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
    check("wr_acks", 32'(ack_n), 32'd4);
    check("wr_done_pulses", 32'(done_n), 32'd1);
    check("wr_err_low", 32'(err), 32'd0);

    // Same write burst with beat 2 stalled for two cycles.
    clear_mon();
    stall_en = 1'b1;
    send_cmd(1'b1, 11'h400, 5'd4);
    wait_done("st_done_seen", 40);
    stall_en = 1'b0;
    check("st_stall_cycles", 32'(stall_seen), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("st_hold_addr", 32'(hold_addr[i]), 32'h402);
      check("st_hold_data", hold_data[i], 32'hAC);
    end
    check("st_accepts", 32'(acc_n), 32'd4);
    check("st_beat2_addr", 32'(acc_addr[2]), 32'h402);
    check("st_beat3_data", acc_data[3], 32'hAD);
    check("st_span", 32'(acc_cyc[3] - acc_cyc[0]), 32'd5);
    check("st_acks", 32'(ack_n), 32'd4);
    check("st_done_pulses", 32'(done_n), 32'd1);
    wdata_valid = 1'b0;

    // Read burst.
    clear_mon();
    send_cmd(1'b0, 11'h010, 5'd3);
    wait_done("rd_done_seen", 40);
    check("rd_beats", 32'(rd_n), 32'd3);
    check("rd_data0", rd_data[0], 32'h11);
    check("rd_data1", rd_data[1], 32'h22);
    check("rd_data2", rd_data[2], 32'h33);
    check("rd_we", 32'(acc_we[0]), 32'd0);
    check("rd_done_pulses", 32'(done_n), 32'd1);

    // Len 0 means 16 beats; address wraps 0x7FF -> 0x000.
    clear_mon();
    send_cmd(1'b0, 11'h7FE, 5'd0);
    wait_done("wrap_done_seen", 80);
    check("wrap_accepts", 32'(acc_n), 32'd16);
    check("wrap_addr0", 32'(acc_addr[0]), 32'h7FE);
    check("wrap_addr1", 32'(acc_addr[1]), 32'h7FF);
    check("wrap_addr2", 32'(acc_addr[2]), 32'h000);
    check("wrap_addr15", 32'(acc_addr[15]), 32'h00D);
    check("wrap_reads", 32'(rd_n), 32'd16);

    // Reset after two accepted beats with acks withheld.
    clear_mon();
    ack_en = 1'b0;
    send_cmd(1'b0, 11'h030, 5'd4);
    begin
      int n = 0;
      while (acc_n < 2 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_two_accepted", 32'(acc_n >= 2), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    clear_mon();
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("late_ack_no_rdata", 32'(rd_n), 32'd0);
    check("late_ack_no_done", 32'(done_n), 32'd0);
    ack_en = 1'b1;
    clear_mon();
    send_cmd(1'b0, 11'h020, 5'd2);
    wait_done("post_rst_done_seen", 40);
    check("post_rst_reads", 32'(rd_n), 32'd2);
    check("post_rst_data0", rd_data[0], 32'h121);
    check("post_rst_data1", rd_data[1], 32'h132);
    check("post_rst_done_pulses", 32'(done_n), 32'd1);

`ifdef DUALPORT_WB_MASTER_TIMEOUT_EN
    // One write beat never acked: watchdog fires TO cycles after the accept cycle,
    // DONE follows on the next edge, so the monitor sees done TO+1 cycles after the accept.
    clear_mon();
    ack_en = 1'b0;
    wd_base = 32'h55;
    wdata_valid = 1'b1;
    send_cmd(1'b1, 11'h050, 5'd1);
    wait_done("to_done_seen", 50);
    check("to_err_set", 32'(err), 32'd1);
    check("to_latency", 32'(done_cyc - acc_cyc[0]), 32'(TO + 1));
    check("to_done_pulses", 32'(done_n), 32'd1);
    ack_en = 1'b1;
    clear_mon();
    send_cmd(1'b1, 11'h051, 5'd1);
    check("to_err_cleared", 32'(err), 32'd0);
    wait_done("to_next_done_seen", 40);
    check("to_next_acks", 32'(ack_n), 32'd1);
    wdata_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dualport_wb_master.md
DUALPORT_WB_MASTER -- requirements
Module: dualport_wb_master

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 11, the Wishbone word-address width; MSB selects the RAM bank.
REQ-002 The block SHALL take parameter DATA_W, default 32, the data width, with SEL_W = DATA_W/8.
REQ-003 The block SHALL take parameter TIMEOUT_CYC, default 64, the ack watchdog limit (used only under the macro).
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_we_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  ADDR_W  start word address
- cmd_len_i  in  5  beats, 1..16; 0 is treated as 16
- cmd_sel_i  in  SEL_W  byte select for every beat
- wdata_valid_i / wdata_ready_o  in/out  1  write-data stream handshake
- wdata_i  in  DATA_W  write beat
- rdata_valid_o  out  1  one-cycle pulse per read ack
- rdata_o  out  DATA_W  read beat
- done_o  out  1  one-cycle burst-complete pulse
- err_o  out  1  sticky timeout flag
- pX_wb_stb_o, pX_wb_we_o, pX_wb_addr_o, pX_wb_sel_o, pX_wb_data_o  out  1/1/ADDR_W/SEL_W/DATA_W  pipelined Wishbone request toward one dualport port
- pX_wb_stall_i, pX_wb_ack_i, pX_wb_data_i  in  1/1/DATA_W  Wishbone response

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-006 cmd_ready_o SHALL be 1 only in IDLE; cmd_valid_i & cmd_ready_o latches the command and moves to ISSUE.
REQ-007 All pX_wb_* outputs SHALL be registered.
REQ-008 A request SHALL be accepted on a cycle with stb_o=1 and stall_i=0. While stall_i=1, stb/we/addr/sel/data SHALL hold unchanged.
REQ-009 In ISSUE, when the request register is empty or being accepted this cycle, the next beat SHALL be loaded back-to-back, giving one request per cycle with no stall.
REQ-010 A read beat SHALL be loaded unconditionally. A write beat SHALL be loaded only when wdata_valid_i=1; wdata_ready_o SHALL equal that load condition.
REQ-011 The beat address SHALL be start + beat index, modulo 2^ADDR_W; 0x7FF wraps to 0x000, crossing banks.
REQ-012 After the last beat is accepted the FSM SHALL go to DRAIN with stb_o=0.
REQ-013 An outstanding counter (0..16) SHALL add 1 per accept and subtract 1 per ack; a simultaneous accept and ack leaves it unchanged.
REQ-014 An ack with zero outstanding SHALL be ignored.
REQ-015 On a read ack, rdata_o SHALL equal wb_data_i and rdata_valid_o SHALL pulse in the following cycle; there is no backpressure.
REQ-016 DRAIN SHALL go to DONE when all beats are issued and the outstanding count is 0 (including when the last ack arrives with the last accept).
REQ-017 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-018 we_o SHALL be held constant for the whole burst.

Reset
REQ-019 On rst_n=0 at a clock edge:
- FSM goes to IDLE
- stb_o, we_o, wdata_ready_o, rdata_valid_o, done_o and err_o are 0; cmd_ready_o is 1 in the following cycle
- addr_o, sel_o, data_o, rdata_o are 0
- counters are cleared
REQ-020 A reset mid-burst SHALL abandon the burst; acks arriving after reset SHALL be ignored.

Configuration
REQ-021 With macro DUALPORT_WB_MASTER_TIMEOUT_EN defined:
- a watchdog counts cycles in ISSUE/DRAIN with no ack while outstanding > 0
- on reaching TIMEOUT_CYC it sets err_o, drops stb_o and forces DONE
- err_o clears on the next command accept or on reset
REQ-022 Without the macro, the watchdog logic SHALL be absent, err_o SHALL be tied to 0, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-023 Package dualport_wb_pkg SHALL hold ADDR_W/DATA_W/SEL_W defaults, the FSM state enum and a wb_req_t struct (we, addr, sel, data).
REQ-024 Sub-module dualport_wb_req_reg SHALL hold the stall-holding request register (stb + wb_req_t, load/accept logic); everything else is in dualport_wb_master.

Verification
REQ-025 Write burst: len=4, addr=0x400, data 0xAA..0xAD, no stall -> accepts on 4 consecutive cycles at 0x400..0x403, then 4 acks and one done_o pulse.
REQ-026 Stall: as REQ-025 with stall_i=1 for 2 cycles during beat 2 -> beat 2 fields held stable for the stall, then the burst completes with 4 acks.
REQ-027 Read burst: len=3 at 0x010, responder returns 0x11/0x22/0x33 -> rdata_valid_o pulses three times with those values in order.
REQ-028 Wrap: len=0 (16 beats) at 0x7FE -> addresses 0x7FE, 0x7FF, 0x000..0x00D.
REQ-029 Reset: rst_n low after 2 accepted beats -> all outputs at reset values in the next cycle, a late ack is ignored, and the next command runs normally.
REQ-030 Timeout (macro defined): acks withheld -> err_o=1 and done_o pulses TIMEOUT_CYC cycles after the last ack-free progress.
